// File: rtl/parametrik_bolucu.sv
// Iterative restoring integer divider (signed/unsigned) that retires ADIM_BIT quotient bits per clock.
// Divide-by-zero and signed overflow skip the iteration and finish in a single fix-up cycle.
module parametrik_bolucu #(
  parameter int VERI_BIT = 32,
  parameter int ADIM_BIT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                istek,
  input  logic                isaretli,
  input  logic [VERI_BIT-1:0] a_g,
  input  logic [VERI_BIT-1:0] b_g,
  input  logic                iptal,
  output logic                hazir,
  output logic [VERI_BIT-1:0] bolum,
  output logic [VERI_BIT-1:0] kalan,
  output logic                bitti
);

  localparam int ADIM_SAY = VERI_BIT / ADIM_BIT;
  localparam int SAY_W    = $clog2(ADIM_SAY + 1);
  localparam logic [SAY_W-1:0]    SAY_BAS   = SAY_W'(ADIM_SAY);
  localparam logic [SAY_W-1:0]    SAY_BIR   = SAY_W'(1);
  localparam logic [VERI_BIT-1:0] EN_KUCUK  = {1'b1, {(VERI_BIT-1){1'b0}}};

  typedef enum logic [1:0] {BOSTA, HESAPLA, DUZELT} durum_t;
  typedef enum logic [1:0] {NORMAL, SIFIR, TASMA} ozel_t;

  durum_t              durum_reg, durum_next;
  ozel_t               ozel_reg;
  logic                sa_reg, sb_reg;
  logic [VERI_BIT-1:0] bolunen_reg;
  logic [VERI_BIT-1:0] bolen_reg;
  logic [VERI_BIT-1:0] ham_a_reg;
  logic [VERI_BIT-1:0] q_reg;
  logic [VERI_BIT:0]   r_reg;
  logic [SAY_W-1:0]    sayac_reg;

  logic                a_neg, b_neg;
  logic [VERI_BIT-1:0] a_mutlak, b_mutlak;
  logic                b_sifir, tasma;
  logic [VERI_BIT:0]   r_next, r_kay;
  logic [VERI_BIT+1:0] fark;
  logic [VERI_BIT-1:0] q_next, d_next;
  logic [VERI_BIT-1:0] q_son, r_son;

  assign hazir    = (durum_reg == BOSTA);
  assign a_neg    = isaretli & a_g[VERI_BIT-1];
  assign b_neg    = isaretli & b_g[VERI_BIT-1];
  assign a_mutlak = a_neg ? -a_g : a_g;
  assign b_mutlak = b_neg ? -b_g : b_g;
  assign b_sifir  = (b_g == '0);
  assign tasma    = isaretli & (a_g == EN_KUCUK) & (b_g == '1);

  // ADIM_BIT chained restoring steps; the extra borrow bit of fark decides each quotient bit.
  always_comb begin
    r_next = r_reg;
    q_next = q_reg;
    d_next = bolunen_reg;
    r_kay  = '0;
    fark   = '0;
    for (int i = 0; i < ADIM_BIT; i++) begin
      r_kay  = {r_next[VERI_BIT-1:0], d_next[VERI_BIT-1]};
      d_next = {d_next[VERI_BIT-2:0], 1'b0};
      fark   = {1'b0, r_kay} - {2'b00, bolen_reg};
      q_next = {q_next[VERI_BIT-2:0], ~fark[VERI_BIT+1]};
      r_next = fark[VERI_BIT+1] ? r_kay : fark[VERI_BIT:0];
    end
  end

  assign q_son = (sa_reg ^ sb_reg) ? -q_reg : q_reg;
  assign r_son = sa_reg ? -r_reg[VERI_BIT-1:0] : r_reg[VERI_BIT-1:0];

  always_comb begin
    durum_next = durum_reg;
    if (iptal) begin
      durum_next = BOSTA;
    end else begin
      case (durum_reg)
        BOSTA:   if (istek) durum_next = (b_sifir | tasma) ? DUZELT : HESAPLA;
        HESAPLA: if (sayac_reg == SAY_BIR) durum_next = DUZELT;
        DUZELT:  durum_next = BOSTA;
        default: durum_next = BOSTA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_reg <= BOSTA;
    end else begin
      durum_reg <= durum_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ozel_reg    <= NORMAL;
      sa_reg      <= 1'b0;
      sb_reg      <= 1'b0;
      bolunen_reg <= '0;
      bolen_reg   <= '0;
      ham_a_reg   <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      sayac_reg   <= '0;
      bolum       <= '0;
      kalan       <= '0;
      bitti       <= 1'b0;
    end else begin
      bitti <= 1'b0;
      // A flush blocks every update, including the final result write.
      if (!iptal) begin
        case (durum_reg)
          BOSTA: begin
            if (istek) begin
              sa_reg      <= a_neg;
              sb_reg      <= b_neg;
              bolunen_reg <= a_mutlak;
              bolen_reg   <= b_mutlak;
              ham_a_reg   <= a_g;
              ozel_reg    <= b_sifir ? SIFIR : (tasma ? TASMA : NORMAL);
              q_reg       <= '0;
              r_reg       <= '0;
              sayac_reg   <= SAY_BAS;
            end
          end
          HESAPLA: begin
            q_reg       <= q_next;
            r_reg       <= r_next;
            bolunen_reg <= d_next;
            sayac_reg   <= sayac_reg - SAY_BIR;
          end
          DUZELT: begin
            bitti <= 1'b1;
            case (ozel_reg)
              SIFIR: begin
                bolum <= '1;
                kalan <= ham_a_reg;
              end
              TASMA: begin
                bolum <= EN_KUCUK;
                kalan <= '0;
              end
              default: begin
                bolum <= q_son;
                kalan <= r_son;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parametrik_bolucu.sv
// Bench for parametrik_bolucu: three instances (ADIM_BIT 1/2/4) share operands and are
// checked against a per-instance queue of expected results, latency included.
module tb_parametrik_bolucu;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         isaretli = 1'b0;
  logic         iptal = 1'b0;
  logic [N-1:0] a_g = '0;
  logic [N-1:0] b_g = '0;
  logic [2:0]   istek = '0;
  logic [2:0]   hazir_v, bitti_v;
  logic [N-1:0] bolum_v [3];
  logic [N-1:0] kalan_v [3];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  parametrik_bolucu #(.VERI_BIT(N), .ADIM_BIT(1)) u_adim1 (
    .clk(clk), .rst_n(rst_n), .istek(istek[0]), .isaretli(isaretli), .a_g(a_g), .b_g(b_g),
    .iptal(iptal), .hazir(hazir_v[0]), .bolum(bolum_v[0]), .kalan(kalan_v[0]), .bitti(bitti_v[0]));
  parametrik_bolucu #(.VERI_BIT(N), .ADIM_BIT(2)) u_adim2 (
    .clk(clk), .rst_n(rst_n), .istek(istek[1]), .isaretli(isaretli), .a_g(a_g), .b_g(b_g),
    .iptal(iptal), .hazir(hazir_v[1]), .bolum(bolum_v[1]), .kalan(kalan_v[1]), .bitti(bitti_v[1]));
  parametrik_bolucu #(.VERI_BIT(N), .ADIM_BIT(4)) u_adim4 (
    .clk(clk), .rst_n(rst_n), .istek(istek[2]), .isaretli(isaretli), .a_g(a_g), .b_g(b_g),
    .iptal(iptal), .hazir(hazir_v[2]), .bolum(bolum_v[2]), .kalan(kalan_v[2]), .bitti(bitti_v[2]));

  typedef struct {
    logic [N-1:0] eb;
    logic [N-1:0] ek;
    int           acc;
    int           lat;
  } beklenen_t;

  typedef struct {
    logic         s;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] eb;
    logic [N-1:0] ek;
    bit           ozel;
  } vektor_t;

  beklenen_t q0[$], q1[$], q2[$];
  vektor_t   tablo [17];

  task automatic denetle(input int k, input string ad, input logic [N-1:0] gercek, input logic [N-1:0] beklenen);
    total++;
    if (gercek !== beklenen) begin
      bad++;
      $display("FAIL %s adim=%0d got=%h want=%h", ad, 1 << k, gercek, beklenen);
    end
  endtask

  task automatic sonuc_kontrol(input int k, input beklenen_t e);
    denetle(k, "bolum", bolum_v[k], e.eb);
    denetle(k, "kalan", kalan_v[k], e.ek);
    denetle(k, "gecikme", N'(cyc - e.acc), N'(e.lat));
    $display("txn adim=%0d bolum=%h kalan=%h gecikme=%0d", 1 << k, bolum_v[k], kalan_v[k], cyc - e.acc);
  endtask

  // Every bitti must match a queued expectation; a stray or over-long pulse finds the queue empty.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (bitti_v[k]) begin
        int sz;
        sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
        total++;
        if (sz == 0) begin
          bad++;
          $display("FAIL beklenmeyen_bitti adim=%0d got=1 want=0", 1 << k);
        end else begin
          case (k)
            0: sonuc_kontrol(0, q0.pop_front());
            1: sonuc_kontrol(1, q1.pop_front());
            default: sonuc_kontrol(2, q2.pop_front());
          endcase
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic basla(input logic [2:0] m, input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit kaydet, input logic [N-1:0] eb, input logic [N-1:0] ek, input bit ozel);
    beklenen_t e;
    isaretli = s;
    a_g = a;
    b_g = b;
    istek = m;
    @(posedge clk);
    @(negedge clk);
    istek = '0;
    a_g = $urandom;
    b_g = $urandom;
    isaretli = ~s;
    if (kaydet) begin
      for (int k = 0; k < 3; k++) begin
        if (m[k]) begin
          e.eb = eb;
          e.ek = ek;
          e.acc = cyc;
          e.lat = ozel ? 1 : N / (1 << k) + 1;
          case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
          endcase
        end
      end
    end
  endtask

  task automatic bekle(input int limit);
    int n;
    int kalan_is;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    kalan_is = q0.size() + q1.size() + q2.size();
    total++;
    if (kalan_is != 0) begin
      bad++;
      $display("FAIL zaman_asimi got=%0d_bekleyen want=0", kalan_is);
      q0.delete();
      q1.delete();
      q2.delete();
    end
  endtask

  task automatic tut_kontrol(input string ad, input logic [N-1:0] eb, input logic [N-1:0] ek);
    for (int k = 0; k < 3; k++) begin
      denetle(k, {ad, "_hazir"}, N'(hazir_v[k]), N'(1));
      denetle(k, {ad, "_bolum"}, bolum_v[k], eb);
      denetle(k, {ad, "_kalan"}, kalan_v[k], ek);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] son_b, son_k;
    int n;

    tablo[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tablo[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    tablo[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    tablo[3]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
    tablo[4]  = '{1'b0, 32'h00001234,   32'd0,          32'hFFFFFFFF,   32'h00001234,   1'b1};
    tablo[5]  = '{1'b1, 32'hFFFFFFF0,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF0,   1'b1};
    tablo[6]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b1};
    tablo[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    tablo[8]  = '{1'b0, 32'hFFFFFFFF,   32'd3,          32'h55555555,   32'd0,          1'b0};
    tablo[9]  = '{1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0};
    tablo[10] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    tablo[11] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0};
    tablo[12] = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
    tablo[13] = '{1'b1, 32'd0,          32'hFFFFFFFB,   32'd0,          32'd0,          1'b0};
    tablo[14] = '{1'b0, 32'hDEADBEEF,   32'h10,         32'h0DEADBEE,   32'hF,          1'b0};
    tablo[15] = '{1'b1, 32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0};
    tablo[16] = '{1'b0, 32'd1000,       32'd33,         32'd30,         32'd10,         1'b0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tut_kontrol("reset", '0, '0);
    for (int k = 0; k < 3; k++) denetle(k, "reset_bitti", N'(bitti_v[k]), N'(0));
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tablo[i]) begin
      basla(3'b111, tablo[i].s, tablo[i].a, tablo[i].b, 1'b1, tablo[i].eb, tablo[i].ek, tablo[i].ozel);
      bekle(60);
    end
    son_b = tablo[16].eb;
    son_k = tablo[16].ek;

    // Flush in the fifth compute cycle: no result, idle next cycle, outputs hold.
    basla(3'b111, 1'b0, 32'd100, 32'd7, 1'b0, '0, '0, 1'b0);
    repeat (4) @(negedge clk);
    iptal = 1'b1;
    @(negedge clk);
    iptal = 1'b0;
    tut_kontrol("iptal_hesapla", son_b, son_k);
    repeat (40) @(negedge clk);
    tut_kontrol("iptal_sonra", son_b, son_k);

    // Flush together with a request: the request is dropped.
    isaretli = 1'b0;
    a_g = 32'd100;
    b_g = 32'd7;
    istek = 3'b111;
    iptal = 1'b1;
    @(negedge clk);
    istek = '0;
    iptal = 1'b0;
    tut_kontrol("iptal_istek", son_b, son_k);
    repeat (5) @(negedge clk);

    // Flush during the fix-up cycle of a divide-by-zero: no write, no bitti.
    basla(3'b111, 1'b0, 32'h1234, 32'd0, 1'b0, '0, '0, 1'b1);
    iptal = 1'b1;
    @(negedge clk);
    iptal = 1'b0;
    tut_kontrol("iptal_duzelt", son_b, son_k);
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-operation clears outputs immediately.
    basla(3'b111, 1'b0, 32'hFFFFFFFF, 32'd3, 1'b0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tut_kontrol("reset_orta", '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Back-to-back on the ADIM_BIT=2 instance: second accept lands in the bitti cycle.
    basla(3'b010, 1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
    n = 0;
    while (!bitti_v[1] && n < 40) begin
      @(negedge clk);
      n++;
    end
    denetle(1, "ardisik_hazir", N'(hazir_v[1]), N'(1));
    basla(3'b010, 1'b0, 32'hFFFFFFFF, 32'd3, 1'b1, 32'h55555555, 32'd0, 1'b0);
    bekle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
